// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM state encodings for the pipelined ALU.
// ALU_MUL_EN adds the MULT state used by the iterative multiplier.
package alu_pkg;
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_INC = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_DEC = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_ADC = 4'h8;
    localparam logic [3:0] OP_SBC = 4'h9;
    localparam logic [3:0] OP_SHL = 4'hA;
    localparam logic [3:0] OP_SHR = 4'hB;
    localparam logic [3:0] OP_ASR = 4'hC;
    localparam logic [3:0] OP_ROL = 4'hD;
    localparam logic [3:0] OP_ROR = 4'hE;
    localparam logic [3:0] OP_MUL = 4'hF;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_V = 1;
    localparam int FLG_C = 0;

`ifdef ALU_MUL_EN
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MULT = 1'b1} state_e;
`else
    typedef enum logic [0:0] {ST_IDLE = 1'b0} state_e;
`endif
endpackage

// File: rtl/alu_if.sv
// Request/response bundle between the decoder side (master) and the ALU (slave).
interface alu_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ALU_Sel;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic [3:0]       NZVC;

    modport master (output in_valid, ALU_Sel, A, B, out_ready,
                    input  in_ready, out_valid, Result, NZVC);
    modport slave  (input  in_valid, ALU_Sel, A, B, out_ready,
                    output in_ready, out_valid, Result, NZVC);
endinterface

// File: rtl/alu_comb.sv
// Combinational datapath for opcodes 0-E; opcode F passes A through with flags from A.
import alu_pkg::*;

module alu_comb #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic [3:0]       sel_i,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       nzvc_o
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;

    always_comb begin
        sum = '0;
        r   = a_i;
        c   = 1'b0;
        v   = 1'b0;
        case (sel_i)
            OP_ADD, OP_ADC: begin
                sum = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, (sel_i == OP_ADC) & cin_i};
                r   = sum[MSB:0];
                c   = sum[WIDTH];
                v   = (a_i[MSB] == b_i[MSB]) && (r[MSB] != a_i[MSB]);
            end
            OP_SUB, OP_SBC: begin
                // Bit WIDTH of the extended difference is the borrow.
                sum = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, (sel_i == OP_SBC) & cin_i};
                r   = sum[MSB:0];
                c   = sum[WIDTH];
                v   = (a_i[MSB] != b_i[MSB]) && (r[MSB] != a_i[MSB]);
            end
            OP_INC: begin
                sum = {1'b0, a_i} + {{WIDTH{1'b0}}, 1'b1};
                r   = sum[MSB:0];
                c   = sum[WIDTH];
                v   = !a_i[MSB] && r[MSB];
            end
            OP_DEC: begin
                sum = {1'b0, a_i} - {{WIDTH{1'b0}}, 1'b1};
                r   = sum[MSB:0];
                c   = sum[WIDTH];
                v   = a_i[MSB] && !r[MSB];
            end
            OP_AND: r = a_i & b_i;
            OP_OR:  r = a_i | b_i;
            OP_XOR: r = a_i ^ b_i;
            OP_NOT: r = ~a_i;
            OP_SHL: begin
                r = {a_i[MSB-1:0], 1'b0};
                c = a_i[MSB];
                v = a_i[MSB] ^ a_i[MSB-1];
            end
            OP_SHR: begin
                r = {1'b0, a_i[MSB:1]};
                c = a_i[0];
            end
            OP_ASR: begin
                r = {a_i[MSB], a_i[MSB:1]};
                c = a_i[0];
            end
            OP_ROL: begin
                r = {a_i[MSB-1:0], a_i[MSB]};
                c = a_i[MSB];
            end
            OP_ROR: begin
                r = {a_i[0], a_i[MSB:1]};
                c = a_i[0];
            end
            default: r = a_i;
        endcase
    end

    assign result_o = r;
    assign nzvc_o   = {r[MSB], r == '0, v, c};
endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides and a persistent NZVC register.
// ALU_MUL_EN: opcode F runs a shift-add unsigned multiply; otherwise F returns A, flags kept.
import alu_pkg::*;

module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic  clk,
    input  logic  reset,
    alu_if.slave  bus
);
    state_e           state_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       nzvc_q;
    logic             out_valid_q;
    logic             out_valid_d;

    logic             in_ready;
    logic             accept;
    logic             single_done;
    logic             mul_done;
    logic [WIDTH-1:0] comb_res;
    logic [3:0]       comb_nzvc;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .a_i      (bus.A),
        .b_i      (bus.B),
        .cin_i    (nzvc_q[FLG_C]),
        .sel_i    (bus.ALU_Sel),
        .result_o (comb_res),
        .nzvc_o   (comb_nzvc)
    );

    // Result slot may drain and refill on the same edge.
    assign in_ready = !reset && (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

`ifdef ALU_MUL_EN
    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               mul_hi;

    assign single_done = accept && (bus.ALU_Sel != OP_MUL);
    assign mul_done    = (state_q == ST_MULT) && (cnt_q == '0);
    assign acc_d       = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_hi      = acc_d[2*WIDTH-1:WIDTH] != '0;
`else
    assign single_done = accept;
    assign mul_done    = 1'b0;
`endif

    assign out_valid_d = (single_done || mul_done) ? 1'b1 :
                         (bus.out_ready ? 1'b0 : out_valid_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            nzvc_q      <= '0;
            out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
            mcand_q     <= '0;
            acc_q       <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            if (single_done) begin
                result_q <= comb_res;
                if (bus.ALU_Sel != OP_MUL)
                    nzvc_q <= comb_nzvc;
            end
`ifdef ALU_MUL_EN
            case (state_q)
                ST_IDLE: begin
                    if (accept && bus.ALU_Sel == OP_MUL) begin
                        state_q  <= ST_MULT;
                        mcand_q  <= {{WIDTH{1'b0}}, bus.A};
                        mplier_q <= bus.B;
                        acc_q    <= '0;
                        cnt_q    <= CNT_W'(WIDTH - 1);
                    end
                end
                ST_MULT: begin
                    // One multiplier bit per clock; the last bit writes the result.
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q  <= ST_IDLE;
                        result_q <= acc_d[WIDTH-1:0];
                        nzvc_q   <= {acc_d[WIDTH-1], acc_d[WIDTH-1:0] == '0, mul_hi, mul_hi};
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.Result    = result_q;
    assign bus.NZVC      = nzvc_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=8 and WIDTH=16; honours ALU_MUL_EN.
import alu_pkg::*;

module tb_alu_pipe;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   bp_en = 1'b0;

    always #5 clk = ~clk;

    alu_if #(.WIDTH(8))  i8  ();
    alu_if #(.WIDTH(16)) i16 ();

    alu_pipe #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(i8));
    alu_pipe #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(i16));

    logic [19:0] q8[$];
    logic [19:0] q16[$];
    logic [3:0]  f8 = '0;
    logic [3:0]  f16 = '0;
    logic [19:0] e8;
    logic [19:0] e16;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: {NZVC, result} for width w, computed in 32-bit with masking.
    function automatic logic [19:0] model(input int w, input logic [3:0] op,
                                          input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] f);
        logic [31:0] m, x, y, full;
        logic [15:0] r;
        logic        c, v;
        logic [3:0]  nf;
        int          s;
        s = w - 1;
        m = (32'd1 << w) - 32'd1;
        x = {16'd0, a} & m;
        y = {16'd0, b} & m;
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_ADD: full = x + y;
            OP_INC: full = x + 32'd1;
            OP_SUB: full = x - y;
            OP_DEC: full = x - 32'd1;
            OP_ADC: full = x + y + {31'd0, f[0]};
            OP_SBC: full = x - y - {31'd0, f[0]};
            OP_AND: full = x & y;
            OP_OR:  full = x | y;
            OP_XOR: full = x ^ y;
            OP_NOT: full = ~x;
            OP_SHL: full = x << 1;
            OP_SHR: full = x >> 1;
            OP_ASR: full = (x >> 1) | ({31'd0, x[s]} << s);
            OP_ROL: full = (x << 1) | {31'd0, x[s]};
            OP_ROR: full = (x >> 1) | ({31'd0, x[0]} << s);
`ifdef ALU_MUL_EN
            default: full = x * y;
`else
            default: full = x;
`endif
        endcase
        r = 16'(full & m);
        case (op)
            OP_ADD, OP_ADC: begin c = full[w]; v = (x[s] == y[s]) && (r[s] != x[s]); end
            OP_SUB, OP_SBC: begin c = full[w]; v = (x[s] != y[s]) && (r[s] != x[s]); end
            OP_INC: begin c = full[w]; v = !x[s] && r[s]; end
            OP_DEC: begin c = full[w]; v = x[s] && !r[s]; end
            OP_SHL: begin c = x[s]; v = x[s] ^ x[s-1]; end
            OP_ROL: c = x[s];
            OP_SHR, OP_ASR, OP_ROR: c = x[0];
            OP_MUL: begin c = (full >> w) != 32'd0; v = c; end
            default: ;
        endcase
        nf = {r[s], r == 16'd0, v, c};
`ifndef ALU_MUL_EN
        if (op == OP_MUL) nf = f;
`endif
        return {nf, r};
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            q8.delete();
            f8 = '0;
        end else begin
            if (i8.out_valid && i8.out_ready) begin
                if (q8.size() == 0) chk("w8_spurious_out", 1, 0);
                else begin
                    e8 = q8.pop_front();
                    chk("w8_result", {24'd0, i8.Result}, {24'd0, e8[7:0]});
                    chk("w8_nzvc", {28'd0, i8.NZVC}, {28'd0, e8[19:16]});
                end
            end
            if (i8.in_valid && i8.in_ready) begin
                e8 = model(8, i8.ALU_Sel, {8'd0, i8.A}, {8'd0, i8.B}, f8);
                f8 = e8[19:16];
                q8.push_back(e8);
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            q16.delete();
            f16 = '0;
        end else begin
            if (i16.out_valid && i16.out_ready) begin
                if (q16.size() == 0) chk("w16_spurious_out", 1, 0);
                else begin
                    e16 = q16.pop_front();
                    chk("w16_result", {16'd0, i16.Result}, {16'd0, e16[15:0]});
                    chk("w16_nzvc", {28'd0, i16.NZVC}, {28'd0, e16[19:16]});
                end
            end
            if (i16.in_valid && i16.in_ready) begin
                e16 = model(16, i16.ALU_Sel, i16.A, i16.B, f16);
                f16 = e16[19:16];
                q16.push_back(e16);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (bp_en) i8.out_ready = 1'($urandom_range(0, 1));
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        i8.in_valid = 1'b1; i8.ALU_Sel = op; i8.A = a; i8.B = b;
        @(negedge clk);
        while (!i8.in_ready && n < 100) begin @(negedge clk); n++; end
        if (!i8.in_ready) chk("w8_accept_timeout", 0, 1);
        @(posedge clk); #1;
        i8.in_valid = 1'b0;
    endtask

    task automatic send16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        i16.in_valid = 1'b1; i16.ALU_Sel = op; i16.A = a; i16.B = b;
        @(negedge clk);
        while (!i16.in_ready && n < 100) begin @(negedge clk); n++; end
        if (!i16.in_ready) chk("w16_accept_timeout", 0, 1);
        @(posedge clk); #1;
        i16.in_valid = 1'b0;
    endtask

`ifdef ALU_MUL_EN
    task automatic mul8(input logic [7:0] a, input logic [7:0] b, input logic [11:0] exp);
        int lat = 0;
        int lo = 0;
        send8(OP_MUL, a, b);
        do begin
            @(negedge clk);
            if (!i8.out_valid) begin
                lat++;
                if (!i8.in_ready) lo++;
            end
        end while (!i8.out_valid && lat < 40);
        chk("mul_latency", lat, 8);
        chk("mul_in_ready_low", lo, 8);
        chk("mul_result", {20'd0, i8.NZVC, i8.Result}, {20'd0, exp});
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        logic [11:0] snap;
        logic [3:0]  prev;
        bit          stray;
        i8.in_valid = 1'b0;  i8.ALU_Sel = '0;  i8.A = '0;  i8.B = '0;  i8.out_ready = 1'b1;
        i16.in_valid = 1'b0; i16.ALU_Sel = '0; i16.A = '0; i16.B = '0; i16.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        i8.in_valid = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, i8.in_ready}, 0);
        chk("rst_out_valid", {31'd0, i8.out_valid}, 0);
        chk("rst_result_nzvc", {20'd0, i8.NZVC, i8.Result}, 0);
        @(posedge clk); #1;
        i8.in_valid = 1'b0;
        reset = 1'b0;

        send8(OP_ADD, 8'h7F, 8'h01);
        @(negedge clk);
        chk("add_7f_01", {19'd0, i8.out_valid, i8.NZVC, i8.Result}, {19'd0, 1'b1, 4'b1010, 8'h80});
        @(posedge clk); #1;
        send8(OP_ADD, 8'hFF, 8'h01);
        #1 chk("add_ff_01", {20'd0, i8.NZVC, i8.Result}, {20'd0, 4'b0101, 8'h00});
        send8(OP_SUB, 8'h00, 8'h01);
        #1 chk("sub_00_01", {20'd0, i8.NZVC, i8.Result}, {20'd0, 4'b1001, 8'hFF});
        send8(OP_SBC, 8'h05, 8'h02);
        #1 chk("sbc_borrow_in", {20'd0, i8.NZVC, i8.Result}, {20'd0, 4'b0000, 8'h02});

        // Back-to-back coverage of every single-cycle op.
        send8(OP_ADD, 8'hFF, 8'hFF); send8(OP_ADC, 8'h10, 8'h20);
        send8(OP_INC, 8'h7F, 8'h00); send8(OP_DEC, 8'h80, 8'h00);
        send8(OP_SUB, 8'h80, 8'h01); send8(OP_SBC, 8'h00, 8'h00);
        send8(OP_AND, 8'hF0, 8'h3C); send8(OP_OR, 8'h00, 8'h00);
        send8(OP_XOR, 8'hAA, 8'h55); send8(OP_NOT, 8'hFF, 8'h00);
        send8(OP_SHL, 8'h40, 8'h00); send8(OP_SHR, 8'h01, 8'h00);
        send8(OP_ASR, 8'h81, 8'h00); send8(OP_ROL, 8'h80, 8'h00);
        send8(OP_ROR, 8'h01, 8'h00);
        #1 chk("ror_8", {20'd0, i8.NZVC, i8.Result}, {20'd0, 4'b1001, 8'h80});

`ifdef ALU_MUL_EN
        mul8(8'h10, 8'h10, {4'b0111, 8'h00});
        mul8(8'h03, 8'h05, {4'b0000, 8'h0F});
        mul8(8'hFF, 8'hFF, {4'b0011, 8'h01});
`else
        prev = f8;
        send8(OP_MUL, 8'h5A, 8'h03);
        #1 chk("opf_passthru", {20'd0, i8.NZVC, i8.Result}, {20'd0, prev, 8'h5A});
`endif

        // Backpressure: a pending result blocks new requests and holds its value.
        send8(OP_XOR, 8'h0F, 8'hF0);
        i8.out_ready = 1'b0;
        i8.in_valid = 1'b1; i8.ALU_Sel = OP_ADD; i8.A = 8'h01; i8.B = 8'h01;
        @(negedge clk);
        snap = {i8.NZVC, i8.Result};
        repeat (4) begin
            @(negedge clk);
            chk("bp_in_ready_low", {31'd0, i8.in_ready}, 0);
            chk("bp_hold", {19'd0, i8.out_valid, i8.NZVC, i8.Result}, {19'd0, 1'b1, snap});
        end
        @(posedge clk); #1;
        i8.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_drain_refill_ready", {31'd0, i8.in_ready}, 1);
        @(posedge clk); #1;
        i8.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_refilled", {19'd0, i8.out_valid, i8.NZVC, i8.Result}, {19'd0, 1'b1, 4'b0000, 8'h02});

        // Random ops under random output backpressure.
        @(posedge clk); #1;
        bp_en = 1'b1;
        repeat (150) send8(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
        bp_en = 1'b0;
        @(posedge clk); #2;
        i8.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("w8_queue_drained", q8.size(), 0);

        // Reset while an op is in flight must not leave a result behind.
        send8(OP_MUL, 8'h03, 8'h05);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midop_rst_state", {19'd0, i8.out_valid, i8.NZVC, i8.Result}, 0);
        chk("midop_rst_in_ready", {31'd0, i8.in_ready}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        stray = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (i8.out_valid) stray = 1'b1;
        end
        chk("midop_rst_no_stray", {31'd0, stray}, 0);
        @(negedge clk);
        chk("midop_rst_in_ready_back", {31'd0, i8.in_ready}, 1);
        @(posedge clk); #1;

        // WIDTH=16 shifts and a short random run.
        send16(OP_SHL, 16'hC000, 16'h0000);
        #1 chk("w16_shl", {12'd0, i16.NZVC, i16.Result}, {12'd0, 4'b1001, 16'h8000});
        send16(OP_ASR, 16'h8001, 16'h0000);
        #1 chk("w16_asr", {12'd0, i16.NZVC, i16.Result}, {12'd0, 4'b1001, 16'hC000});
        send16(OP_ROR, 16'h0001, 16'h0000);
        #1 chk("w16_ror", {12'd0, i16.NZVC, i16.Result}, {12'd0, 4'b1001, 16'h8000});
        repeat (60) send16(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
        repeat (20) @(posedge clk);
        #1 chk("w16_queue_drained", q16.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
